// File: rtl/shift_reg_univ.sv
// Parametrised universal shift register with rotate, arithmetic shift, sync clear
// and an autonomous burst engine that repeats one shift operation a counted number of times.
module shift_reg_univ #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             D,
    input  logic [2:0]       mode_i,
    input  logic [WIDTH-1:0] par_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] cnt_i,
    output logic [WIDTH-1:0] P,
    output logic             so_msb_o,
    output logic             so_lsb_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BURST = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [WIDTH-1:0] p_q, p_d;
    logic [1:0]       state_q, state_d;
    logic [2:0]       mode_q, mode_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_sat;
    logic             is_shift;

    function automatic logic [WIDTH-1:0] apply_op(input logic [2:0] op,
                                                  input logic [WIDTH-1:0] cur,
                                                  input logic [WIDTH-1:0] ld,
                                                  input logic din);
        logic [WIDTH-1:0] res;
        case (op)
            3'd0:    res = cur;
            3'd1:    res = ld;
            3'd2:    res = {cur[WIDTH-2:0], din};
            3'd3:    res = {din, cur[WIDTH-1:1]};
            3'd4:    res = {cur[WIDTH-2:0], cur[WIDTH-1]};
            3'd5:    res = {cur[0], cur[WIDTH-1:1]};
            3'd6:    res = {cur[WIDTH-1], cur[WIDTH-1:1]};
            default: res = '0;
        endcase
        return res;
    endfunction

    assign cnt_sat  = (cnt_i > WIDTH_C) ? WIDTH_C : cnt_i;
    assign is_shift = (mode_i >= 3'd2) && (mode_i <= 3'd6);

    always_comb begin
        p_d     = p_q;
        state_d = state_q;
        mode_d  = mode_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && is_shift) begin
                    mode_d = mode_i;
                    // The start edge itself performs shift #1, so a count of N
                    // leaves N-1 for the burst state.
                    if (cnt_sat == '0) begin
                        rem_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        p_d = apply_op(mode_i, p_q, par_i, D);
                        if (cnt_sat == ONE_C) begin
                            rem_d   = '0;
                            state_d = S_DONE;
                        end else begin
                            rem_d   = cnt_sat - ONE_C;
                            state_d = S_BURST;
                        end
                    end
                end else begin
                    p_d = apply_op(mode_i, p_q, par_i, D);
                end
            end
            S_BURST: begin
                p_d   = apply_op(mode_q, p_q, par_i, D);
                rem_d = rem_q - ONE_C;
                if (rem_q == ONE_C) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            p_q     <= '0;
            state_q <= S_IDLE;
            mode_q  <= '0;
            rem_q   <= '0;
        end else begin
            p_q     <= p_d;
            state_q <= state_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
        end
    end

    assign P        = p_q;
    assign so_msb_o = p_q[WIDTH-1];
    assign so_lsb_o = p_q[0];
    assign busy_o   = (state_q == S_BURST);
    assign done_o   = (state_q == S_DONE);

endmodule

// File: tb/tb_shift_reg_univ.sv
// Bench for shift_reg_univ: directed scenarios plus randomized traffic checked
// against a counted-shift behavioural model; a second 16-bit instance covers WIDTH.
`timescale 1ns/1ps
module tb_shift_reg_univ;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       nrst;
    logic       d8, start8, so_msb8, so_lsb8, busy8, done8;
    logic [2:0] mode8;
    logic [7:0] par8, p8;
    logic [3:0] cnt8;

    logic        d16, start16, so_msb16, so_lsb16, busy16, done16;
    logic [2:0]  mode16;
    logic [15:0] par16, p16;
    logic [4:0]  cnt16;

    shift_reg_univ #(.WIDTH(8)) dut8 (
        .clk(clk), .nrst(nrst), .D(d8), .mode_i(mode8), .par_i(par8),
        .start_i(start8), .cnt_i(cnt8), .P(p8), .so_msb_o(so_msb8),
        .so_lsb_o(so_lsb8), .busy_o(busy8), .done_o(done8)
    );

    shift_reg_univ #(.WIDTH(16)) dut16 (
        .clk(clk), .nrst(nrst), .D(d16), .mode_i(mode16), .par_i(par16),
        .start_i(start16), .cnt_i(cnt16), .P(p16), .so_msb_o(so_msb16),
        .so_lsb_o(so_lsb16), .busy_o(busy16), .done_o(done16)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model of the 8-bit instance: shifts still owed and a pending done flag.
    int unsigned m_p;
    int          m_owed;
    bit          m_donep;
    int unsigned m_mode;

    function automatic int unsigned ref_op(int w, int unsigned m, int unsigned p,
                                           int unsigned par, int unsigned d);
        int unsigned mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 1);
        int unsigned msb  = (p >> (w - 1)) & 1;
        case (m)
            0: return p;
            1: return par & mask;
            2: return ((p * 2) + d) & mask;
            3: return (p / 2) + (d << (w - 1));
            4: return ((p * 2) + msb) & mask;
            5: return (p / 2) + ((p % 2) << (w - 1));
            6: return (p / 2) + (msb << (w - 1));
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_p = 0; m_owed = 0; m_donep = 0; m_mode = 0;
    endtask

    task automatic cycle8(input int m, input int d, input int par, input int st, input int cnt);
        int n;
        mode8 = m[2:0]; d8 = d[0]; par8 = par[7:0]; start8 = st[0]; cnt8 = cnt[3:0];
        @(posedge clk);
        if (m_donep) begin
            m_donep = 0;
        end else if (m_owed > 0) begin
            m_p = ref_op(8, m_mode, m_p, 0, d);
            m_owed--;
            if (m_owed == 0) m_donep = 1;
        end else if (st != 0 && m >= 2 && m <= 6) begin
            n = (cnt > 8) ? 8 : cnt;
            m_mode = m;
            if (n == 0) begin
                m_donep = 1;
            end else begin
                m_p = ref_op(8, m, m_p, par, d);
                m_owed = n - 1;
                if (m_owed == 0) m_donep = 1;
            end
        end else begin
            m_p = ref_op(8, m, m_p, par, d);
        end
        #1;
    endtask

    task automatic test_reset();
        nrst = 1'b0; mode8 = 3'd1; par8 = 8'h77; d8 = 1'b1; start8 = 1'b0; cnt8 = 4'd0;
        mode16 = 3'd1; par16 = 16'h7777; d16 = 1'b0; start16 = 1'b0; cnt16 = 5'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (p8 !== 8'h00 || busy8 !== 1'b0 || done8 !== 1'b0) begin
            errors++; $display("FAIL reset_hold: P=%h busy=%b done=%b want 00 0 0", p8, busy8, done8);
        end
        @(negedge clk);
        nrst = 1'b1;
        mode8 = 3'd0; mode16 = 3'd0;
        #1;
        checks++;
        if (p8 !== 8'h00) begin errors++; $display("FAIL reset_release: P=%h want 00", p8); end
        cycle8(0, 1, 8'h55, 0, 0);
        checks++;
        if (p8 !== 8'h00) begin errors++; $display("FAIL reset_after: P=%h want 00", p8); end
        $display("test_reset done");
    endtask

    task automatic test_compat();
        int shl_bits[10] = '{1,0,1,0,1,0,1,0,1,1};
        int shr_bits[6]  = '{1,0,1,0,1,0};
        foreach (shl_bits[i]) cycle8(2, shl_bits[i], 0, 0, 0);
        checks++;
        if (p8 !== 8'hAB) begin errors++; $display("FAIL compat_shl: P=%h want AB", p8); end
        cycle8(7, 0, 0, 0, 0);
        checks++;
        if (p8 !== 8'h00) begin errors++; $display("FAIL compat_clr: P=%h want 00", p8); end
        foreach (shr_bits[i]) cycle8(3, shr_bits[i], 0, 0, 0);
        checks++;
        if (p8 !== 8'h54) begin errors++; $display("FAIL compat_shr: P=%h want 54", p8); end
        cycle8(7, 0, 0, 0, 0);
        cycle8(0, 1, 8'h55, 0, 0);
        cycle8(0, 0, 8'h55, 0, 0);
        checks++;
        if (p8 !== 8'h00) begin errors++; $display("FAIL compat_hold: P=%h want 00", p8); end
        $display("test_compat done");
    endtask

    task automatic test_rotate_asr();
        cycle8(1, 0, 8'hA5, 0, 0);
        cycle8(4, 0, 0, 0, 0);
        checks++;
        if (p8 !== 8'h4B || so_msb8 !== 1'b0 || so_lsb8 !== 1'b1) begin
            errors++; $display("FAIL rol: P=%h msb=%b lsb=%b want 4B 0 1", p8, so_msb8, so_lsb8);
        end
        cycle8(5, 0, 0, 0, 0);
        checks++;
        if (p8 !== 8'hA5) begin errors++; $display("FAIL ror: P=%h want A5", p8); end
        cycle8(1, 0, 8'h80, 0, 0);
        cycle8(6, 1, 0, 0, 0);
        checks++;
        if (p8 !== 8'hC0) begin errors++; $display("FAIL asr: P=%h want C0", p8); end
        $display("test_rotate_asr done");
    endtask

    task automatic test_burst();
        logic [7:0] want_p[4] = '{8'hC0, 8'hE0, 8'hF0, 8'hF0};
        logic       want_b[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic       want_d[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        cycle8(1, 0, 8'h81, 0, 0);
        cycle8(6, 0, 0, 1, 3);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cycle8(1, 1, 8'hFF, 1, 5);
            checks++;
            if (p8 !== want_p[i] || busy8 !== want_b[i] || done8 !== want_d[i]) begin
                errors++;
                $display("FAIL burst_step%0d: P=%h busy=%b done=%b want %h %b %b",
                         i, p8, busy8, done8, want_p[i], want_b[i], want_d[i]);
            end
        end
        cycle8(0, 0, 0, 0, 0);
        checks++;
        if (p8 !== 8'hF0 || done8 !== 1'b0) begin
            errors++; $display("FAIL burst_idle: P=%h done=%b want F0 0", p8, done8);
        end
        $display("test_burst done");
    endtask

    task automatic test_edges();
        cycle8(1, 0, 8'h5A, 0, 0);
        cycle8(2, 1, 0, 1, 0);
        checks++;
        if (p8 !== 8'h5A || busy8 !== 1'b0 || done8 !== 1'b1) begin
            errors++; $display("FAIL cnt0: P=%h busy=%b done=%b want 5A 0 1", p8, busy8, done8);
        end
        cycle8(0, 0, 0, 0, 0);
        cycle8(1, 0, 8'h01, 0, 0);
        cycle8(4, 0, 0, 1, 15);
        for (int i = 1; i <= 7; i++) begin
            cycle8(0, 0, 0, 0, 0);
            checks++;
            if (busy8 !== (i < 7) || p8 !== m_p[7:0]) begin
                errors++; $display("FAIL sat_step%0d: P=%h busy=%b want %h %b", i, p8, busy8, m_p[7:0], (i < 7));
            end
        end
        checks++;
        if (p8 !== 8'h01 || done8 !== 1'b1) begin
            errors++; $display("FAIL sat_end: P=%h done=%b want 01 1", p8, done8);
        end
        cycle8(0, 0, 0, 0, 0);
        cycle8(1, 0, 8'h3C, 1, 3);
        cycle8(0, 0, 0, 0, 0);
        checks++;
        if (p8 !== 8'h3C || busy8 !== 1'b0 || done8 !== 1'b0) begin
            errors++; $display("FAIL start_load: P=%h busy=%b done=%b want 3C 0 0", p8, busy8, done8);
        end
        $display("test_edges done");
    endtask

    task automatic test_reset_mid_burst();
        cycle8(7, 0, 0, 0, 0);
        cycle8(2, 1, 0, 1, 8);
        for (int i = 0; i < 3; i++) cycle8(0, 1, 0, 0, 0);
        checks++;
        if (p8 !== 8'h0F || busy8 !== 1'b1) begin
            errors++; $display("FAIL midburst_pre: P=%h busy=%b want 0F 1", p8, busy8);
        end
        nrst = 1'b0;
        #1;
        model_reset();
        checks++;
        if (p8 !== 8'h00 || busy8 !== 1'b0 || done8 !== 1'b0) begin
            errors++; $display("FAIL midburst_abort: P=%h busy=%b done=%b want 00 0 0", p8, busy8, done8);
        end
        @(negedge clk);
        nrst = 1'b1;
        cycle8(0, 1, 0, 0, 0);
        checks++;
        if (p8 !== 8'h00 || busy8 !== 1'b0) begin
            errors++; $display("FAIL midburst_after: P=%h busy=%b want 00 0", p8, busy8);
        end
        $display("test_reset_mid_burst done");
    endtask

    task automatic test_width16();
        int unsigned exp16;
        mode16 = 3'd1; par16 = 16'h8001; start16 = 1'b0;
        @(posedge clk); #1;
        exp16 = 16'h8001;
        mode16 = 3'd5; cnt16 = 5'd4; start16 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            exp16 = ref_op(16, 5, exp16, 0, 0);
            mode16 = 3'd1; par16 = 16'hFFFF; start16 = 1'b1;
            checks++;
            if (p16 !== exp16[15:0] || busy16 !== (i < 3)) begin
                errors++; $display("FAIL w16_step%0d: P=%h busy=%b want %h %b", i, p16, busy16, exp16[15:0], (i < 3));
            end
        end
        checks++;
        if (p16 !== 16'h1800 || done16 !== 1'b1) begin
            errors++; $display("FAIL w16_final: P=%h done=%b want 1800 1", p16, done16);
        end
        mode16 = 3'd0; start16 = 1'b0;
        @(posedge clk); #1;
        $display("test_width16 done");
    endtask

    task automatic test_random();
        int m, st, cnt;
        for (int i = 0; i < 400; i++) begin
            m   = int'($urandom_range(0, 7));
            if (m == 7 && $urandom_range(0, 3) != 0) m = 2;
            st  = ($urandom_range(0, 5) == 0) ? 1 : 0;
            cnt = int'($urandom_range(0, 15));
            cycle8(m, int'($urandom_range(0, 1)), int'($urandom_range(0, 255)), st, cnt);
            checks++;
            if (p8 !== m_p[7:0] || busy8 !== (m_owed > 0) || done8 !== m_donep ||
                so_msb8 !== m_p[7] || so_lsb8 !== m_p[0]) begin
                errors++;
                $display("FAIL random%0d: P=%h busy=%b done=%b want %h %b %b",
                         i, p8, busy8, done8, m_p[7:0], (m_owed > 0), m_donep);
            end
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_compat();
        test_rotate_asr();
        test_burst();
        test_edges();
        test_reset_mid_burst();
        test_width16();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
